// File: rtl/microfono_pkg.sv
// Shared constants and types for the microfono I2S MEMS microphone receiver.
// The STEREO_EN macro enables right-slot capture and the ch output.
package microfono_pkg;

    localparam int CLK_DIV_D   = 4;
    localparam int SLOT_BITS_D = 32;
    localparam int DATA_BITS_D = 18;

    localparam int BIT_CNT_W_D = $clog2(SLOT_BITS_D);

    typedef logic [DATA_BITS_D-1:0] sample_t;

    // Single-cycle strobes marking the clk edge on which mclk toggles.
    typedef struct packed {
        logic rise;
        logic fall;
    } mclk_evt_t;

    // Counter width that stays legal for degenerate ranges of 0..n-1.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/microfono_clkgen.sv
// Bit-clock / word-select generator: half-period divider, mclk, rise/fall
// event strobes, slot bit counter and ws.
module microfono_clkgen
    import microfono_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_D,
    parameter int SLOT_BITS = SLOT_BITS_D,
    parameter int CNT_W     = cnt_w(SLOT_BITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    output logic             mclk_o,
    output logic             ws_o,
    output mclk_evt_t        evt_o,
    output logic [CNT_W-1:0] bit_cnt_o
);

    localparam int HALF  = CLK_DIV / 2;
    localparam int DIV_W = cnt_w(HALF);

    logic [DIV_W-1:0] div_q, div_d;
    logic             mclk_q, mclk_d;
    logic             ws_q, ws_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             tc;

    always_comb begin
        tc         = enable_i && (div_q == DIV_W'(HALF - 1));
        evt_o.rise = tc && !mclk_q;
        evt_o.fall = tc && mclk_q;

        div_d     = tc ? '0 : div_q + 1'b1;
        mclk_d    = mclk_q ^ tc;
        ws_d      = ws_q;
        bit_cnt_d = bit_cnt_q;

        // The slot counter advances on falls so that data, which the
        // microphone changes after a fall, is stable at the following rise.
        if (evt_o.fall) begin
            if (bit_cnt_q == CNT_W'(SLOT_BITS - 1)) begin
                bit_cnt_d = '0;
                ws_d      = !ws_q;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        if (!enable_i) begin
            div_d     = '0;
            mclk_d    = 1'b0;
            ws_d      = 1'b0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            mclk_q    <= 1'b0;
            ws_q      <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            div_q     <= div_d;
            mclk_q    <= mclk_d;
            ws_q      <= ws_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign mclk_o    = mclk_q;
    assign ws_o      = ws_q;
    assign bit_cnt_o = bit_cnt_q;

endmodule

// File: rtl/microfono.sv
// I2S MEMS microphone receiver top: drives mclk/ws, deserialises the slot
// MSB-first and strobes done with each sample. STEREO_EN adds right slot + ch.
module microfono
    import microfono_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_D,
    parameter int SLOT_BITS = SLOT_BITS_D,
    parameter int DATA_BITS = DATA_BITS_D
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 dataint,
    output logic                 mclk,
    output logic                 ws,
    output logic [DATA_BITS-1:0] data,
`ifdef STEREO_EN
    output logic                 ch,
`endif
    output logic                 done
);

    localparam int CNT_W = cnt_w(SLOT_BITS);

`ifdef STEREO_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif

    mclk_evt_t        evt;
    logic [CNT_W-1:0] bit_cnt;
    logic             ws_w;

    microfono_clkgen #(
        .CLK_DIV   (CLK_DIV),
        .SLOT_BITS (SLOT_BITS),
        .CNT_W     (CNT_W)
    ) u_clkgen (
        .clk       (clk),
        .rst_n     (reset),
        .enable_i  (enable),
        .mclk_o    (mclk),
        .ws_o      (ws_w),
        .evt_o     (evt),
        .bit_cnt_o (bit_cnt)
    );

    assign ws = ws_w;

    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 ch_q, ch_d;
    logic [DATA_BITS:0]   ext;
    logic                 slot_on, in_word, last_bit;

    always_comb begin
        // Appending at the LSB keeps this legal down to DATA_BITS == 1.
        ext      = {shift_q, dataint};
        slot_on  = STEREO || !ws_w;
        in_word  = (bit_cnt != '0) && (bit_cnt <= CNT_W'(DATA_BITS));
        last_bit = (bit_cnt == CNT_W'(DATA_BITS));

        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ch_d    = ch_q;

        if (bit_cnt == '0) begin
            shift_d = '0;
        end

        if (evt.rise && slot_on && in_word) begin
            shift_d = ext[DATA_BITS-1:0];
            if (last_bit) begin
                data_d = ext[DATA_BITS-1:0];
                done_d = 1'b1;
                ch_d   = ws_w;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ch_q    <= 1'b0;
        end else if (!enable) begin
            // A partial word is dropped; the last complete sample survives.
            shift_q <= '0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ch_q    <= ch_d;
        end
    end

    assign data = data_q;
    assign done = done_q;

`ifdef STEREO_EN
    assign ch = ch_q;
`else
    logic unused_ch;
    assign unused_ch = ch_q;
`endif

endmodule

// File: tb/tb_microfono.sv
// Directed bench for microfono: a small I2S microphone model feeds words on
// mclk falls; timing and captured samples are checked against hand values.
module tb_microfono;
    import microfono_pkg::*;

    localparam int DB = 18;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b1;
    logic          dataint = 1'b0;
    wire           mclk, ws, done;
    wire [DB-1:0]  data;
`ifdef STEREO_EN
    wire           ch;
`endif

    microfono dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .dataint (dataint),
        .mclk    (mclk),
        .ws      (ws),
        .data    (data),
`ifdef STEREO_EN
        .ch      (ch),
`endif
        .done    (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Microphone model: changes data just after each mclk fall, MSB at slot bit 1.
    sample_t left_w, right_w, w_cur;
    logic    fill;
    int      m_cnt = 0;
    logic    m_ws = 1'b0;
    logic    prev_mclk = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!reset || !enable) begin
            m_cnt = 0;
            m_ws  = 1'b0;
        end else if (prev_mclk && !mclk) begin
            if (m_cnt == 31) begin
                m_cnt = 0;
                m_ws  = !m_ws;
            end else begin
                m_cnt++;
            end
        end
        prev_mclk = mclk;
        w_cur = m_ws ? right_w : left_w;
        if (m_cnt >= 1 && m_cnt <= DB) dataint = w_cur[DB-m_cnt];
        else dataint = fill;
    end

    task automatic wait_left(input int max, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < max && !ok) begin
            @(posedge clk); #1;
            n++;
`ifdef STEREO_EN
            if (done === 1'b1 && ch === 1'b0) ok = 1'b1;
`else
            if (done === 1'b1) ok = 1'b1;
`endif
        end
    endtask

    int       bad, mbad, first_rise, first_ws, ws_back, d1, d2, ndone, n;
    bit       ok;
    logic     exp_m;
    logic [DB-1:0] data1, dA, dB;
    logic     cA, cB;

    initial begin
        left_w = '1; right_w = '1; fill = 1'b1;

        // Reset held with enable high
        reset = 1'b0; enable = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("rst_mclk", mclk, 0);
        chk("rst_ws", ws, 0);
        chk("rst_done", done, 0);
        chk("rst_data", data, 0);

        @(negedge clk); reset = 1'b1; enable = 1'b0;
        bad = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (mclk !== 1'b0 || ws !== 1'b0) bad++;
        end
        chk("idle_mclk", bad, 0);

        // Enable: clock timing with constant-one data
        @(negedge clk); enable = 1'b1;
        first_rise = 0; first_ws = 0; ws_back = 0; d1 = 0; d2 = 0; ndone = 0; mbad = 0;
        data1 = '0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            exp_m = (i >= 2) ? (((i - 2) / 2) % 2 == 0) : 1'b0;
            if (mclk !== exp_m) mbad++;
            if (mclk === 1'b1 && first_rise == 0) first_rise = i;
            if (ws === 1'b1 && first_ws == 0) first_ws = i;
            if (ws === 1'b0 && first_ws != 0 && ws_back == 0) ws_back = i;
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin d1 = i; data1 = data; end
                else if (ndone == 2) d2 = i;
            end
        end
        chk("first_rise", first_rise, 2);
        chk("mclk_pattern", mbad, 0);
        chk("ws_first", first_ws, 128);
        chk("ws_back", ws_back, 256);
        chk("done1_edge", d1, 74);
        chk("ones_data", data1, 18'h3FFFF);
`ifdef STEREO_EN
        chk("done2_edge", d2, 202);
        chk("done_count", ndone, 3);
`else
        chk("done2_edge", d2, 330);
        chk("done_count", ndone, 2);
`endif

        // Alternating patterns in successive frames
        left_w = 18'h2AAAA; right_w = '0; fill = 1'b0;
        wait_left(600, n, ok);
        chk("to_2aaaa", ok, 1);
        chk("left_edge", n, 186);
        chk("data_2aaaa", data, 18'h2AAAA);
        left_w = 18'h15555;
        wait_left(600, n, ok);
        chk("to_15555", ok, 1);
        chk("frame_period", n, 256);
        chk("data_15555", data, 18'h15555);
        @(posedge clk); #1;
        chk("done_width", done, 0);

        // Left all zero, right all one
        left_w = '0; right_w = '1;
        wait_left(600, n, ok);
        chk("to_lr", ok, 1);
        chk("data_left0", data, 0);
        ndone = 0; bad = 0; dA = '1; dB = '1; cA = 1'b1; cB = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++;
`ifdef STEREO_EN
                if (ndone == 1) begin dA = data; cA = ch; end
                else begin dB = data; cB = ch; end
`else
                dA = data;
`endif
            end
        end
`ifdef STEREO_EN
        chk("lr_dones", ndone, 2);
        chk("right_data", dA, 18'h3FFFF);
        chk("right_ch", cA, 1);
        chk("left_data", dB, 0);
        chk("left_ch", cB, 0);
`else
        chk("lr_dones", ndone, 1);
        chk("lr_data", dA, 0);
`endif

        // Enable dropped at bit_cnt 10 of the left slot
        left_w = 18'h0F0F0;
        wait_left(600, n, ok);
        chk("data_0f0f0", data, 18'h0F0F0);
        left_w = 18'h12345;
        repeat (223) @(posedge clk);
        @(negedge clk); enable = 1'b0;
        @(posedge clk); #1;
        chk("dis_mclk", mclk, 0);
        chk("dis_ws", ws, 0);
        chk("dis_data", data, 18'h0F0F0);
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || mclk !== 1'b0) bad++;
        end
        chk("dis_quiet", bad, 0);
        chk("dis_hold", data, 18'h0F0F0);

        left_w = 18'h1D2E7;
        @(negedge clk); enable = 1'b1;
        @(posedge clk); #1;
        chk("reen_ws", ws, 0);
        wait_left(600, n, ok);
        chk("reen_edge", n, 73);
        chk("reen_data", data, 18'h1D2E7);

        // Asynchronous reset while done is high
        wait_left(600, n, ok);
        chk("to_rstdone", ok, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_done", done, 0);
        chk("arst_data", data, 0);
        chk("arst_mclk", mclk, 0);
        @(negedge clk); reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/microfono.md
Name: microfono

Overview:
- Receiver for a digital I2S MEMS microphone.
- Generates the microphone's bit clock (mclk) and word-select (ws) from the system clock.
- Samples serial data (dataint) and deserialises the left-channel sample MSB-first.
- Presents each sample on a parallel bus with a one-cycle done strobe, for the audio/PCM datapath downstream.

Parameters:
- CLK_DIV, 4: clk cycles per mclk period; even, >=2.
- SLOT_BITS, 32: mclk periods per ws half-frame (one channel slot).
- DATA_BITS, 18: significant sample bits per slot; 1 <= DATA_BITS <= SLOT_BITS-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  run enable; low stops and re-initialises the interface.
- dataint  input  1  serial data from the microphone.
- mclk  output  1  bit clock to the microphone (registered).
- ws  output  1  word select: 0 = left slot, 1 = right slot (registered).
- data  output  DATA_BITS  last complete sample, MSB-first assembled.
- done  output  1  one-clk strobe, data updated.
- ch  output  1  channel of current data; exists only with STEREO_EN.

Behaviour:
- Reset (reset=0, async): mclk=0, ws=0, done=0, data=0, ch=0; divider, bit counter and shift register cleared.
- enable=0 (synchronous), next clk edge:
  - divider=0, bit_cnt=0, mclk=0, ws=0, done=0, shift register cleared.
  - data and ch hold their last value.
- Divider:
  - half counter 0..CLK_DIV/2-1; on the terminal count mclk toggles.
  - Rise event = toggle 0->1; fall event = toggle 1->0.
  - After enable rises, the first rise occurs CLK_DIV/2 clk cycles later.
- Slot counter bit_cnt (0..SLOT_BITS-1):
  - increments on each fall event.
  - On the fall event with bit_cnt==SLOT_BITS-1 it wraps to 0 and ws toggles.
  - ws period = 2*SLOT_BITS*CLK_DIV clk cycles.
- Sampling (standard I2S one-bit delay):
  - On each rise event with ws=0 and 1 <= bit_cnt <= DATA_BITS, dataint shifts into the shift register LSB side (MSB first).
  - bit_cnt=0 and bit_cnt > DATA_BITS are ignored.
- Completion: on the rise event sampling bit_cnt==DATA_BITS in the captured slot:
  - data <= {shift[DATA_BITS-2:0], dataint}; done <= 1 at the same edge.
  - done returns to 0 on the next clk edge (exactly 1 clk wide).
  - The shift register clears at the next bit_cnt==0.
- Rate: exactly one done per ws frame (left slot only) when STEREO_EN is off.
- enable dropped mid-slot: the partial word is discarded, no done; restart begins at bit_cnt=0, ws=0.
- reset during done: done cleared immediately.

Optional Feature:
- Macro STEREO_EN.
- Defined:
  - both slots are captured.
  - done pulses twice per frame.
  - output ch = ws value of the slot just completed (0 left, 1 right), updated with data.
- Undefined: right slot ignored; ch port absent.

Decomposition:
- Package microfono_pkg:
  - default constants CLK_DIV_D=4, SLOT_BITS_D=32, DATA_BITS_D=18.
  - typedef of the sample word.
  - localparam for the bit_cnt width, $clog2(SLOT_BITS).
- One sub-module, microfono_clkgen: divider, mclk, rise/fall event pulses, bit_cnt, ws.
- The top holds the shift register, data, done, ch.

Test Plan (CLK_DIV=4, SLOT_BITS=32, DATA_BITS=18):
1. Hold reset=0 with enable=1 -> mclk=ws=done=0, data=0. Release with enable=0 for 50 clk -> mclk stays 0.
2. enable=1 -> first mclk rise after 2 clk, then toggles every 2 clk; ws first toggles after 128 clk, then every 128 clk.
3. dataint=1 constant -> done high exactly 1 clk, data=18'h3FFFF. Next done 256 clk later.
4. Drive 18'h2AAAA MSB-first, changing on mclk falls for left bits 1..18 -> data=18'h2AAAA at done. Then 18'h15555 in the next frame -> data=18'h15555.
5. Left slot all 0, right slot all 1 -> data=0, one done per frame. With STEREO_EN: alternating data=0/ch=0 and data=18'h3FFFF/ch=1, two dones per frame.
6. Deassert enable at bit_cnt=10 of the left slot -> mclk=0 next clk, no done, data holds. Re-enable -> ws=0 and a full 18-bit capture of fresh data.
